v_red_unit: RTL and testbench



---
 rtl/v_red_unit.sv | 170 +++++++++++++++++
 tb/tb_v_red_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_red_unit.sv
// v_red_unit: sequential RVV reduction (VREDSUM / VREDMAX) over vs2, seeded by vs1[0].
// Walks one element per cycle at SEW width and returns a sign-extended scalar for vd[0].
// Optional feature: define V_RED_MIN_EN to make VREDMIN (funct6 6'b000101) legal.
module v_red_unit #(
    parameter int unsigned VLEN = 128,
    parameter int unsigned ELEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [5:0]               i_funct6,
    input  logic [1:0]               i_vsew,
    input  logic [$clog2(VLEN/8):0]  i_vl,
    input  logic [VLEN-1:0]          i_vs2,
    input  logic [ELEN-1:0]          i_vs1,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [ELEN-1:0]          o_result,
    output logic                     o_err
);

    localparam int unsigned IdxW = $clog2(VLEN/8);
    localparam int unsigned VlW  = IdxW + 1;

    localparam logic [5:0] F6Sum = 6'b000000;
    localparam logic [5:0] F6Max = 6'b000111;
    localparam logic [5:0] F6Min = 6'b000101;

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e            state_q, state_d;
    logic [5:0]        f6_q, f6_d;
    logic [1:0]        sew_q, sew_d;
    logic [VLEN-1:0]   vs2_q, vs2_d;
    logic [ELEN-1:0]   acc_q, acc_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [VlW-1:0]    cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              min_ok;
    logic              op_legal;
    logic [VlW-1:0]    max_el;
    logic [VlW-1:0]    vl_clamp;
    logic [ELEN-1:0]   elem;
    logic [ELEN-1:0]   sum;

    // Sign-extend the low SEW bits of v to the full scalar width.
    function automatic logic [ELEN-1:0] sext_sew(input logic [ELEN-1:0] v, input logic [1:0] sew);
        case (sew)
            2'b00:   return {{(ELEN-8){v[7]}}, v[7:0]};
            2'b01:   return {{(ELEN-16){v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

`ifdef V_RED_MIN_EN
    assign min_ok = (i_funct6 == F6Min);
`else
    assign min_ok = 1'b0;
`endif

    assign op_legal = (i_vsew != 2'b11) &&
                      ((i_funct6 == F6Sum) || (i_funct6 == F6Max) || min_ok);

    // Element count clamp: vl beyond VLEN/SEW is silently limited.
    always_comb begin
        case (i_vsew)
            2'b00:   max_el = VlW'(VLEN/8);
            2'b01:   max_el = VlW'(VLEN/16);
            default: max_el = VlW'(VLEN/32);
        endcase
        vl_clamp = (i_vl > max_el) ? max_el : i_vl;
    end

    // Current element of the captured vs2, sign-extended, plus the wrapped SEW-width sum.
    always_comb begin
        case (sew_q)
            2'b00:   elem = sext_sew({{(ELEN-8){1'b0}}, vs2_q[32'(idx_q)*8 +: 8]}, 2'b00);
            2'b01:   elem = sext_sew({{(ELEN-16){1'b0}}, vs2_q[32'(idx_q)*16 +: 16]}, 2'b01);
            default: elem = vs2_q[32'(idx_q)*32 +: 32];
        endcase
        sum = sext_sew(acc_q + elem, sew_q);
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            f6_q    <= '0;
            sew_q   <= '0;
            vs2_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f6_q    <= f6_d;
            sew_q   <= sew_d;
            vs2_q   <= vs2_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: capture on accept, fold one element per ACCUM cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        f6_d    = f6_q;
        sew_d   = sew_q;
        vs2_d   = vs2_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    f6_d  = i_funct6;
                    sew_d = i_vsew;
                    vs2_d = i_vs2;
                    idx_d = '0;
                    cnt_d = vl_clamp;
                    if (!op_legal) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        acc_d   = sext_sew(i_vs1, i_vsew);
                        state_d = (vl_clamp == '0) ? StDone : StAccum;
                    end
                end
            end
            StAccum: begin
                if (f6_q == F6Max) begin
                    acc_d = ($signed(elem) > $signed(acc_q)) ? elem : acc_q;
`ifdef V_RED_MIN_EN
                end else if (f6_q == F6Min) begin
                    acc_d = ($signed(elem) < $signed(acc_q)) ? elem : acc_q;
`endif
                end else begin
                    acc_d = sum;
                end
                idx_d = idx_q + 1'b1;
                if ({1'b0, idx_q} == cnt_q - VlW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and result outputs decoded from registered state.
    always_comb begin
        o_ready  = (state_q == StIdle);
        o_valid  = (state_q == StDone);
        o_result = acc_q;
        o_err    = err_q;
    end

endmodule

// File: tb/tb_v_red_unit.sv
// tb_v_red_unit: directed plan cases plus randomized ops against an arithmetic reference model.
module tb_v_red_unit;

    localparam int unsigned VLEN = 128;
    localparam int unsigned ELEN = 32;
    localparam int unsigned VlW  = $clog2(VLEN/8) + 1;

`ifdef V_RED_MIN_EN
    localparam bit MinEn = 1'b1;
`else
    localparam bit MinEn = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            i_valid;
    logic            o_ready;
    logic [5:0]      i_funct6;
    logic [1:0]      i_vsew;
    logic [VlW-1:0]  i_vl;
    logic [VLEN-1:0] i_vs2;
    logic [ELEN-1:0] i_vs1;
    logic            o_valid;
    logic            i_ready;
    logic [ELEN-1:0] o_result;
    logic            o_err;

    int n_cmp = 0;
    int n_bad = 0;

    v_red_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_funct6 (i_funct6),
        .i_vsew   (i_vsew),
        .i_vl     (i_vl),
        .i_vs2    (i_vs2),
        .i_vs1    (i_vs1),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint to_s(input longint v, input int bits);
        longint m;
        longint r;
        m = (longint'(1) << bits) - 1;
        r = v & m;
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return r;
    endfunction

    // Reference: plain signed arithmetic over the element list.
    task automatic model(input logic [5:0] f6, input logic [1:0] sew, input logic [VlW-1:0] vl,
                         input logic [VLEN-1:0] vs2, input logic [31:0] vs1,
                         output logic [31:0] res, output logic err, output int lat);
        int              bits;
        int              n;
        int              cnt;
        longint          acc;
        longint          e;
        logic [VLEN-1:0] t;
        bit              legal;
        legal = (sew != 2'b11) && (f6 == 6'd0 || f6 == 6'd7 || (MinEn && f6 == 6'd5));
        if (!legal) begin
            res = 32'h0;
            err = 1'b1;
            lat = 0;
        end else begin
            bits = 8 << sew;
            n    = VLEN / bits;
            cnt  = (int'(vl) > n) ? n : int'(vl);
            acc  = to_s(longint'(vs1), bits);
            for (int i = 0; i < cnt; i++) begin
                t = vs2 >> (i * bits);
                e = to_s(longint'(t[63:0]), bits);
                if (f6 == 6'd0)      acc = to_s(acc + e, bits);
                else if (f6 == 6'd7) acc = (e > acc) ? e : acc;
                else                 acc = (e < acc) ? e : acc;
            end
            res = acc[31:0];
            err = 1'b0;
            lat = cnt;
        end
    endtask

    task automatic scramble();
        i_funct6 = 6'($urandom);
        i_vsew   = 2'($urandom);
        i_vl     = VlW'($urandom);
        i_vs2    = {$urandom, $urandom, $urandom, $urandom};
        i_vs1    = $urandom;
    endtask

    // Issue one op, measure latency, check result, apply backpressure, then transfer.
    task automatic run_op(input logic [5:0] f6, input logic [1:0] sew, input logic [VlW-1:0] vl,
                          input logic [VLEN-1:0] vs2, input logic [31:0] vs1, input int hold,
                          output logic [31:0] got_res, output logic got_err);
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        model(f6, sew, vl, vs2, vs1, exp_res, exp_err, exp_lat);
        check("idle_ready", 32'(o_ready), 32'd1);
        i_funct6 = f6;
        i_vsew   = sew;
        i_vl     = vl;
        i_vs2    = vs2;
        i_vs1    = vs1;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        scramble();
        lat = 0;
        while (!o_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", o_result, exp_res);
        check("err", 32'(o_err), 32'(exp_err));
        got_res = o_result;
        got_err = o_err;
        i_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            scramble();
            @(posedge clk);
            #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_result", o_result, exp_res);
            check("hold_err", 32'(o_err), 32'(exp_err));
            check("hold_ready", 32'(o_ready), 32'd0);
        end
        // A zero-length op offered on the transfer edge must not be taken.
        i_valid  = 1'b1;
        i_funct6 = 6'd0;
        i_vsew   = 2'b00;
        i_vl     = '0;
        i_ready  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("xfer_valid", 32'(o_valid), 32'd0);
        check("xfer_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin : main
        logic [31:0] r;
        logic        er;
        logic [1:0]  sew;
        logic [5:0]  f6;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_funct6 = '0;
        i_vsew  = '0;
        i_vl    = '0;
        i_vs2   = '0;
        i_vs1   = '0;
        #2;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'h0);
        check("rst_err", 32'(o_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(6'd0, 2'b10, VlW'(4), {32'd4, 32'd3, 32'd2, 32'd1}, 32'd10, 0, r, er);
        check("tp_sum32", r, 32'd20);
        run_op(6'd0, 2'b00, VlW'(16), {16{8'h20}}, 32'd0, 0, r, er);
        check("tp_sum8_wrap", r, 32'h0);
        run_op(6'd7, 2'b01, VlW'(3), {80'h0, 16'h0001, 16'h7FFF, 16'h8000}, 32'hFFFF, 0, r, er);
        check("tp_max16_a", r, 32'h0000_7FFF);
        run_op(6'd7, 2'b01, VlW'(2), {96'h0, 16'hFFFE, 16'h8000}, 32'h8001, 0, r, er);
        check("tp_max16_b", r, 32'hFFFF_FFFE);
        run_op(6'd0, 2'b00, VlW'(0), {4{32'h1234_5678}}, 32'hAB, 0, r, er);
        check("tp_vl0", r, 32'hFFFF_FFAB);
        run_op(6'd0, 2'b11, VlW'(4), {4{32'h1}}, 32'h5, 0, r, er);
        check("tp_badsew_err", 32'(er), 32'd1);
        check("tp_badsew_res", r, 32'h0);
        run_op(6'd0, 2'b10, VlW'(20), {32'd4, 32'd3, 32'd2, 32'd1}, 32'd0, 5, r, er);
        check("tp_clamp", r, 32'd10);

        // Reset in the middle of a 16-element walk.
        i_funct6 = 6'd0;
        i_vsew   = 2'b00;
        i_vl     = VlW'(16);
        i_vs2    = {16{8'h01}};
        i_vs1    = 32'd0;
        i_valid  = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_result", o_result, 32'h0);
        #3;
        rst = 1'b0;
        run_op(6'd0, 2'b10, VlW'(4), {32'd4, 32'd3, 32'd2, 32'd1}, 32'd10, 0, r, er);
        check("post_rst_sum", r, 32'd20);

        run_op(6'd5, 2'b00, VlW'(2), {112'h0, 8'hF0, 8'h05}, 32'h10, 0, r, er);
        check("tp_min_res", r, MinEn ? 32'hFFFF_FFF0 : 32'h0);
        check("tp_min_err", 32'(er), MinEn ? 32'd0 : 32'd1);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    f6 = 6'd0;
                2, 3:    f6 = 6'd7;
                4:       f6 = 6'd5;
                default: f6 = 6'($urandom);
            endcase
            sew = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_op(f6, sew, VlW'($urandom_range(0, 20)), {$urandom, $urandom, $urandom, $urandom},
                   $urandom, int'($urandom_range(0, 3)), r, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
